// File: rtl/preload_sequencer_if.sv
// rtl/preload_sequencer_if.sv - host weight/activation streams and tile memory write ports
interface preload_sequencer_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  w_valid;
  logic [7:0]            w_data;
  logic                  w_ready;
  logic                  a_valid;
  logic [6:0]            a_data;
  logic                  a_ready;
  logic [7:0]            Weight;
  logic [ADDR_WIDTH-1:0] Weight_Mem_Address_in;
  logic                  weight_wr;
  logic [6:0]            Activation;
  logic [ADDR_WIDTH-1:0] Activation_Mem_Address_in;
  logic                  act_wr;

  modport master (
    output w_valid, w_data, a_valid, a_data,
    input  w_ready, a_ready,
    input  Weight, Weight_Mem_Address_in, weight_wr,
    input  Activation, Activation_Mem_Address_in, act_wr
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_data,
    output w_ready, a_ready,
    output Weight, Weight_Mem_Address_in, weight_wr,
    output Activation, Activation_Mem_Address_in, act_wr
  );
endinterface

// File: rtl/preload_sequencer.sv
// rtl/preload_sequencer.sv - loads a weight/activation tile, then sequences weight reduction, preload and compute
module preload_sequencer #(
  parameter int SIZE           = 8,
  parameter int MEM_SIZE       = SIZE*SIZE,
  parameter int ADDR_WIDTH     = $clog2(MEM_SIZE),
  parameter int WPU_WAIT       = MEM_SIZE+4,
  parameter int PRELOAD_CYCLES = 3*SIZE,
  parameter int CAL_CYCLES     = 4*SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  preload_sequencer_if.slave bus,
  output logic               load_mem_done,
  output logic               PreLoad_CWeight,
  output logic               Cal,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W  = $clog2(MEM_SIZE+1);
  localparam int PH_MAX = (WPU_WAIT > PRELOAD_CYCLES)
                          ? ((WPU_WAIT > CAL_CYCLES) ? WPU_WAIT : CAL_CYCLES)
                          : ((PRELOAD_CYCLES > CAL_CYCLES) ? PRELOAD_CYCLES : CAL_CYCLES);
  localparam int PH_W   = $clog2(PH_MAX+1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WPU_WAIT, S_PRELOAD, S_CAL, S_FINISH
  } state_t;

  state_t          state, state_next;
  logic [CNT_W-1:0] w_cnt, a_cnt, w_cnt_next, a_cnt_next;
  logic [PH_W-1:0]  phase, phase_next;
  logic             w_xfer, a_xfer;

  logic                  w_ready_q, a_ready_q, weight_wr_q, act_wr_q;
  logic [7:0]            weight_q;
  logic [6:0]            act_q;
  logic [ADDR_WIDTH-1:0] w_addr_q, a_addr_q;
  logic                  lmd_q, pre_q, cal_q, busy_q, done_q;

  always_comb begin
    state_next = state;
    w_xfer     = 1'b0;
    a_xfer     = 1'b0;
    unique case (state)
      S_IDLE:     if (start) state_next = S_LOAD;
      S_LOAD: begin
        w_xfer = bus.w_valid && w_ready_q;
        a_xfer = bus.a_valid && a_ready_q;
        if (w_cnt == CNT_W'(MEM_SIZE) && a_cnt == CNT_W'(MEM_SIZE))
          state_next = S_WPU_WAIT;
      end
      S_WPU_WAIT: if (phase == PH_W'(WPU_WAIT-1))       state_next = S_PRELOAD;
      S_PRELOAD:  if (phase == PH_W'(PRELOAD_CYCLES-1)) state_next = S_CAL;
      S_CAL:      if (phase == PH_W'(CAL_CYCLES-1))     state_next = S_FINISH;
      S_FINISH:   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase

    // Abort wins over everything, including a transfer or LOAD completion this cycle.
    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
      w_xfer     = 1'b0;
      a_xfer     = 1'b0;
    end

    // Counts only live inside LOAD, so any later tile restarts at address 0.
    w_cnt_next = (state_next == S_LOAD) ? w_cnt + CNT_W'(w_xfer) : '0;
    a_cnt_next = (state_next == S_LOAD) ? a_cnt + CNT_W'(a_xfer) : '0;
    phase_next = (state_next != state || state_next == S_IDLE) ? '0 : phase + PH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      w_cnt       <= '0;
      a_cnt       <= '0;
      phase       <= '0;
      w_ready_q   <= 1'b0;
      a_ready_q   <= 1'b0;
      weight_wr_q <= 1'b0;
      act_wr_q    <= 1'b0;
      weight_q    <= '0;
      act_q       <= '0;
      w_addr_q    <= '0;
      a_addr_q    <= '0;
      lmd_q       <= 1'b0;
      pre_q       <= 1'b0;
      cal_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      w_cnt       <= w_cnt_next;
      a_cnt       <= a_cnt_next;
      phase       <= phase_next;
      w_ready_q   <= (state_next == S_LOAD) && (w_cnt_next < CNT_W'(MEM_SIZE));
      a_ready_q   <= (state_next == S_LOAD) && (a_cnt_next < CNT_W'(MEM_SIZE));
      weight_wr_q <= w_xfer;
      act_wr_q    <= a_xfer;
      if (w_xfer) begin
        weight_q <= bus.w_data;
        w_addr_q <= w_cnt[ADDR_WIDTH-1:0];
      end
      if (a_xfer) begin
        act_q    <= bus.a_data;
        a_addr_q <= a_cnt[ADDR_WIDTH-1:0];
      end
      lmd_q  <= (state_next == S_WPU_WAIT) || (state_next == S_PRELOAD) ||
                (state_next == S_CAL) || (state_next == S_FINISH);
      pre_q  <= (state_next == S_PRELOAD);
      cal_q  <= (state_next == S_CAL);
      busy_q <= (state_next != S_IDLE);
      done_q <= (state_next == S_FINISH);
    end
  end

  assign bus.w_ready                   = w_ready_q;
  assign bus.a_ready                   = a_ready_q;
  assign bus.Weight                    = weight_q;
  assign bus.Weight_Mem_Address_in     = w_addr_q;
  assign bus.weight_wr                 = weight_wr_q;
  assign bus.Activation                = act_q;
  assign bus.Activation_Mem_Address_in = a_addr_q;
  assign bus.act_wr                    = act_wr_q;
  assign load_mem_done                 = lmd_q;
  assign PreLoad_CWeight               = pre_q;
  assign Cal                           = cal_q;
  assign busy                          = busy_q;
  assign done                          = done_q;

endmodule

// File: tb/tb_preload_sequencer.sv
// tb/tb_preload_sequencer.sv - scoreboard bench for preload_sequencer with SIZE=2
module tb_preload_sequencer;
  localparam int SIZE     = 2;
  localparam int MEM_SIZE = 4;
  localparam int AW       = 2;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic load_mem_done, PreLoad_CWeight, Cal, busy, done;

  preload_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  preload_sequencer #(.SIZE(SIZE)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .bus             (bus.slave),
    .load_mem_done   (load_mem_done),
    .PreLoad_CWeight (PreLoad_CWeight),
    .Cal             (Cal),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_strobe = -100;
  logic [9:0] w_q[$];
  logic [8:0] a_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the oldest accepted beat.
  always @(negedge clk) begin
    logic [9:0] we;
    logic [8:0] ae;
    if (bus.weight_wr === 1'b1) begin
      last_strobe = cyc;
      checks++;
      if (w_q.size() == 0) begin
        failures++;
        $display("FAIL w_strobe_unexpected addr=%0d data=%0h expected none", bus.Weight_Mem_Address_in, bus.Weight);
      end else begin
        we = w_q.pop_front();
        if ({bus.Weight_Mem_Address_in, bus.Weight} !== we) begin
          failures++;
          $display("FAIL w_write got addr=%0d data=%0h expected addr=%0d data=%0h",
                   bus.Weight_Mem_Address_in, bus.Weight, we[9:8], we[7:0]);
        end
      end
    end
    if (bus.act_wr === 1'b1) begin
      last_strobe = cyc;
      checks++;
      if (a_q.size() == 0) begin
        failures++;
        $display("FAIL a_strobe_unexpected addr=%0d data=%0h expected none", bus.Activation_Mem_Address_in, bus.Activation);
      end else begin
        ae = a_q.pop_front();
        if ({bus.Activation_Mem_Address_in, bus.Activation} !== ae) begin
          failures++;
          $display("FAIL a_write got addr=%0d data=%0h expected addr=%0d data=%0h",
                   bus.Activation_Mem_Address_in, bus.Activation, ae[8:7], ae[6:0]);
        end
      end
    end
  end

  task automatic drive_w(input int stall, input int n);
    int i = 0;
    int guard = 0;
    logic [7:0] d;
    repeat (stall) @(negedge clk);
    d = 8'($urandom);
    while (i < n && guard < 200) begin
      @(negedge clk);
      guard++;
      bus.w_valid = 1'b1;
      bus.w_data  = d;
      if (bus.w_ready === 1'b1) begin
        w_q.push_back({2'(i), d});
        i++;
        d = 8'($urandom);
      end
    end
    @(negedge clk);
    bus.w_valid = 1'b0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL w_drive_timeout accepted=%0d expected=%0d", i, n);
    end
  endtask

  task automatic drive_a(input int stall, input int n);
    int i = 0;
    int guard = 0;
    logic [6:0] d;
    repeat (stall) @(negedge clk);
    d = 7'($urandom);
    while (i < n && guard < 200) begin
      @(negedge clk);
      guard++;
      bus.a_valid = 1'b1;
      bus.a_data  = d;
      if (bus.a_ready === 1'b1) begin
        a_q.push_back({2'(i), d});
        i++;
        d = 7'($urandom);
      end
    end
    @(negedge clk);
    bus.a_valid = 1'b0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL a_drive_timeout accepted=%0d expected=%0d", i, n);
    end
  endtask

  // Called at a negedge; returns at the negedge where load_mem_done first reads 1.
  task automatic run_load(input int w_stall, input int a_stall, input bit chk_stall);
    int g = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      drive_w(w_stall, MEM_SIZE);
      drive_a(a_stall, MEM_SIZE);
      begin
        if (chk_stall) begin
          repeat (7) @(negedge clk);
          checks++;
          if ({bus.w_ready, bus.a_ready, load_mem_done, busy} !== 4'b0101) begin
            failures++;
            $display("FAIL stall_hold got w_ready=%b a_ready=%b lmd=%b busy=%b expected 0 1 0 1",
                     bus.w_ready, bus.a_ready, load_mem_done, busy);
          end
        end
      end
    join
    while (load_mem_done !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (load_mem_done !== 1'b1 || (cyc - last_strobe) != 1) begin
      failures++;
      $display("FAIL lmd_timing got lmd=%b delay=%0d expected lmd=1 delay=1", load_mem_done, cyc - last_strobe);
    end
    checks++;
    if (w_q.size() != 0 || a_q.size() != 0) begin
      failures++;
      $display("FAIL load_queues got w_left=%0d a_left=%0d expected 0 0", w_q.size(), a_q.size());
    end
  endtask

  // Starts at the first load_mem_done cycle (index 0) and follows the tile to IDLE.
  task automatic observe_run(input bit poke_start);
    int idx = 0;
    int first_pre = -1, first_cal = -1, done_idx = -1;
    int n_pre = 0, n_cal = 0, n_done = 0, both = 0, lmd_drop = 0;
    while (busy === 1'b1 && idx < 100) begin
      if (PreLoad_CWeight === 1'b1) begin
        if (first_pre < 0) first_pre = idx;
        n_pre++;
      end
      if (Cal === 1'b1) begin
        if (first_cal < 0) first_cal = idx;
        n_cal++;
      end
      if (PreLoad_CWeight === 1'b1 && Cal === 1'b1) both++;
      if (done === 1'b1) begin
        n_done++;
        done_idx = idx;
      end
      if (load_mem_done !== 1'b1) lmd_drop++;
      start = (poke_start && idx == 10);
      @(negedge clk);
      idx++;
    end
    start = 1'b0;
    checks++;
    if (first_pre != 8 || n_pre != 6) begin
      failures++;
      $display("FAIL preload_window got first=%0d len=%0d expected first=8 len=6", first_pre, n_pre);
    end
    checks++;
    if (first_cal != 14 || n_cal != 8) begin
      failures++;
      $display("FAIL cal_window got first=%0d len=%0d expected first=14 len=8", first_cal, n_cal);
    end
    checks++;
    if (n_done != 1 || done_idx != 22) begin
      failures++;
      $display("FAIL done_pulse got count=%0d at=%0d expected count=1 at=22", n_done, done_idx);
    end
    checks++;
    if (both != 0 || lmd_drop != 0) begin
      failures++;
      $display("FAIL overlap_lmd got overlap=%0d lmd_low=%0d expected 0 0", both, lmd_drop);
    end
    checks++;
    if ({busy, load_mem_done, done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_run got busy=%b lmd=%b done=%b expected 0 0 0", busy, load_mem_done, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.a_valid = 1'b0; bus.a_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.w_ready, bus.a_ready, bus.weight_wr, bus.act_wr, bus.Weight, bus.Activation,
         bus.Weight_Mem_Address_in, bus.Activation_Mem_Address_in,
         load_mem_done, PreLoad_CWeight, Cal, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b w_ready=%b lmd=%b expected all zero", busy, bus.w_ready, load_mem_done);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    run_load(0, 0, 1'b0);
    observe_run(1'b0);
  endtask

  task automatic test_back_to_back();
    run_load(1, 0, 1'b0);
    observe_run(1'b1);
  endtask

  task automatic test_stall();
    run_load(0, 6, 1'b1);
    observe_run(1'b0);
  endtask

  task automatic test_abort();
    int g = 0;
    int seen_done = 0;
    run_load(0, 2, 1'b0);
    while (Cal !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (Cal !== 1'b1) begin
      failures++;
      $display("FAIL abort_reach_cal got Cal=%b expected 1", Cal);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({Cal, PreLoad_CWeight, load_mem_done, busy, done,
         bus.w_ready, bus.a_ready, bus.weight_wr, bus.act_wr} !== '0) begin
      failures++;
      $display("FAIL abort_clear got Cal=%b Pre=%b lmd=%b busy=%b done=%b expected all 0",
               Cal, PreLoad_CWeight, load_mem_done, busy, done);
    end
    repeat (5) begin
      if (done === 1'b1) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_no_done got pulses=%0d expected 0", seen_done);
    end
    run_load(0, 0, 1'b0);
    observe_run(1'b0);
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_w(0, 2);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.w_ready, bus.a_ready, bus.weight_wr, bus.act_wr, bus.Weight, bus.Activation,
         bus.Weight_Mem_Address_in, bus.Activation_Mem_Address_in,
         load_mem_done, PreLoad_CWeight, Cal, busy, done} !== '0) begin
      failures++;
      $display("FAIL rst_mid_load got busy=%b w_ready=%b addr=%0d data=%0h expected all zero",
               busy, bus.w_ready, bus.Weight_Mem_Address_in, bus.Weight);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, bus.w_ready, bus.a_ready} !== 3'b000) begin
      failures++;
      $display("FAIL rst_start_ignored got busy=%b w_ready=%b a_ready=%b expected 0 0 0",
               busy, bus.w_ready, bus.a_ready);
    end
    checks++;
    if (w_q.size() != 0) begin
      failures++;
      $display("FAIL rst_queue got w_left=%0d expected 0", w_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_stall();
    test_abort();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/preload_sequencer.md
PRELOAD_SEQUENCER -- requirements
Module: preload_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning systolic array dimension.
REQ-002 SHALL have parameter MEM_SIZE, default SIZE*SIZE, meaning weight and activation words per tile.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_SIZE), meaning memory address width.
REQ-004 SHALL have parameter WPU_WAIT, default MEM_SIZE+4, meaning cycles allowed for weight reduction after load.
REQ-005 SHALL have parameter PRELOAD_CYCLES, default 3*SIZE, meaning duration of compensation-weight preload.
REQ-006 SHALL have parameter CAL_CYCLES, default 4*SIZE, meaning duration of the compute window.
REQ-007 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); one clock, reset synchronous and active-high.
REQ-008 SHALL have ports start (input, 1, begin tile) and abort (input, 1, cancel sequence).
REQ-009 SHALL have ports w_valid (input, 1), w_data (input, 8), and w_ready (output, 1), forming the host weight stream.
REQ-010 SHALL have ports a_valid (input, 1), a_data (input, 7), and a_ready (output, 1), forming the host activation stream.
REQ-011 SHALL have ports Weight (output, 8), Weight_Mem_Address_in (output, ADDR_WIDTH), and weight_wr (output, 1, write strobe).
REQ-012 SHALL have ports Activation (output, 7), Activation_Mem_Address_in (output, ADDR_WIDTH), and act_wr (output, 1, write strobe).
REQ-013 SHALL have ports load_mem_done, PreLoad_CWeight, and Cal (outputs, 1 each, pre-load unit controls).
REQ-014 SHALL have ports busy (output, 1, not IDLE) and done (output, 1, tile-complete pulse).

Function
REQ-015 SHALL implement the states IDLE, LOAD, WPU_WAIT, PRELOAD, CAL, and FINISH, with all outputs registered.
REQ-016 SHALL go from IDLE to LOAD on start=1; start SHALL be ignored in every other state.
REQ-017 SHALL, in LOAD, drive w_ready=1 while weight count < MEM_SIZE and a_ready=1 while activation count < MEM_SIZE; ready SHALL be 0 in all other states.
REQ-018 SHALL treat a transfer as valid&&ready; on the next cycle it SHALL present data and address = pre-increment count, with the matching wr=1 for exactly one cycle.
REQ-019 SHALL accept the weight and activation streams independently and in any interleaving, including simultaneous transfers.
REQ-020 SHALL leave Weight, Activation, and both addresses holding their last values when there is no transfer.
REQ-021 SHALL, when both counts reach MEM_SIZE, set load_mem_done=1 on the cycle after the last write strobe and enter WPU_WAIT.
REQ-022 SHALL hold load_mem_done=1 through WPU_WAIT, PRELOAD, CAL, and FINISH, and clear it on return to IDLE.
REQ-023 SHALL stay in WPU_WAIT for exactly WPU_WAIT cycles, then enter PRELOAD.
REQ-024 SHALL assert PreLoad_CWeight=1 for exactly PRELOAD_CYCLES consecutive cycles in PRELOAD, then enter CAL.
REQ-025 SHALL assert Cal=1 for exactly CAL_CYCLES consecutive cycles in CAL, then enter FINISH.
REQ-026 SHALL never assert PreLoad_CWeight and Cal in the same cycle.
REQ-027 SHALL pulse done=1 for one cycle in FINISH and then enter IDLE; busy SHALL be 1 in every state except IDLE.
REQ-028 SHALL use one shared phase counter, sized for max(WPU_WAIT, PRELOAD_CYCLES, CAL_CYCLES), clearing it on every state entry.
REQ-029 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next cycle with all controls, readies, strobes, and done cleared, and without pulsing done.
REQ-030 SHALL have abort take priority over every other transition, including a LOAD completion in the same cycle.
REQ-031 SHALL, on a start in the cycle after FINISH, begin a new tile with both counts at 0.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, enter IDLE and clear every output, both counts, and the phase counter to 0, regardless of state.
REQ-033 SHALL give rst priority over abort and start.

Verification
REQ-034 SHALL verify, with SIZE=2: start, then 4 weights and 4 activations with valid held high -> addresses 0..3 with strobes, load_mem_done rising one cycle after the 4th strobe.
REQ-035 SHALL verify, with SIZE=2: weights complete while activations stall for 5 cycles -> w_ready=0 after 4 weights, state held in LOAD until the 4th activation.
REQ-036 SHALL verify, with SIZE=2: a full run -> WPU_WAIT of 8 cycles, PreLoad_CWeight high for 6 cycles, Cal high for 8 cycles, one done pulse, busy low afterwards.
REQ-037 SHALL verify that abort asserted on the 3rd Cal cycle -> next cycle all controls 0, no done, and a following start reloads from address 0.
REQ-038 SHALL verify that rst asserted mid-LOAD after 2 writes -> all outputs 0 next cycle, with start ignored while rst=1.
REQ-039 SHALL verify that start pulsed during PRELOAD -> no effect on state or counters.
